// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// FSM state encoding and datapath/register-address widths.
package mips_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

endpackage

// File: rtl/access_timer.sv
// Enable-and-clear cycle counter for the ACCESS state; timeout_hit flags the
// last permitted wait cycle so the controller can abort before the count wraps.
module access_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic timeout_hit
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout_hit = en & (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: converts EX/MEM memory-control bits into a req/ack data
// memory transaction, stalls upstream until completion and registers the WB bundle.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    input  logic                      mem_to_reg_i,
    input  logic                      reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     read_data_2_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [DATA_WIDTH-1:0]     dmem_addr_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_ack_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      stall_o,
    output logic                      wb_valid_o,
    output logic                      wb_reg_write_o,
    output logic                      wb_mem_to_reg_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_write_register_o,
    output logic [DATA_WIDTH-1:0]     wb_alu_result_o,
    output logic [DATA_WIDTH-1:0]     wb_read_data_o,
    output logic                      timeout_o
);

    state_t                    state;
    logic                      access;
    logic                      in_access;
    logic                      timeout_hit;
    logic                      lat_mem_to_reg;
    logic                      lat_reg_write;
    logic [REG_ADDR_WIDTH-1:0] lat_write_register;

    assign access    = mem_read_i | mem_write_i;
    assign in_access = (state == ACCESS);

    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .en         (in_access),
        .clr        (in_access & (dmem_ack_i | timeout_hit)),
        .timeout_hit(timeout_hit)
    );

    // Stall is gated by reset so it drops immediately alongside the flops.
    always_comb begin
        stall_o = 1'b0;
        if (reset) begin
            if (in_access) stall_o = ~dmem_ack_i & ~timeout_hit;
            else           stall_o = access;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            dmem_req_o          <= 1'b0;
            dmem_we_o           <= 1'b0;
            dmem_addr_o         <= '0;
            dmem_wdata_o        <= '0;
            lat_mem_to_reg      <= 1'b0;
            lat_reg_write       <= 1'b0;
            lat_write_register  <= '0;
            wb_valid_o          <= 1'b0;
            wb_reg_write_o      <= 1'b0;
            wb_mem_to_reg_o     <= 1'b0;
            wb_write_register_o <= '0;
            wb_alu_result_o     <= '0;
            wb_read_data_o      <= '0;
            timeout_o           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state              <= ACCESS;
                        dmem_req_o         <= 1'b1;
                        dmem_we_o          <= mem_write_i;
                        dmem_addr_o        <= alu_result_i;
                        dmem_wdata_o       <= read_data_2_i;
                        lat_mem_to_reg     <= mem_to_reg_i;
                        lat_reg_write      <= reg_write_i;
                        lat_write_register <= write_register_i;
                        wb_valid_o         <= 1'b0;
                    end else begin
                        wb_valid_o          <= 1'b1;
                        wb_reg_write_o      <= reg_write_i;
                        wb_mem_to_reg_o     <= mem_to_reg_i;
                        wb_write_register_o <= write_register_i;
                        wb_alu_result_o     <= alu_result_i;
                        wb_read_data_o      <= '0;
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a coincident timeout.
                    if (dmem_ack_i) begin
                        state               <= IDLE;
                        dmem_req_o          <= 1'b0;
                        wb_valid_o          <= 1'b1;
                        wb_reg_write_o      <= lat_reg_write;
                        wb_mem_to_reg_o     <= lat_mem_to_reg;
                        wb_write_register_o <= lat_write_register;
                        wb_alu_result_o     <= dmem_addr_o;
                        wb_read_data_o      <= dmem_we_o ? '0 : dmem_rdata_i;
                    end else if (timeout_hit) begin
                        state               <= IDLE;
                        dmem_req_o          <= 1'b0;
                        timeout_o           <= 1'b1;
                        wb_valid_o          <= 1'b1;
                        wb_reg_write_o      <= 1'b0;
                        wb_mem_to_reg_o     <= lat_mem_to_reg;
                        wb_write_register_o <= lat_write_register;
                        wb_alu_result_o     <= dmem_addr_o;
                        wb_read_data_o      <= '0;
                    end else begin
                        wb_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4 instance).
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
    logic [4:0]  write_register_i;
    logic [31:0] alu_result_i, read_data_2_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o;
    logic [4:0]  wb_write_register_o;
    logic [31:0] wb_alu_result_o, wb_read_data_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_read_i         (mem_read_i),
        .mem_write_i        (mem_write_i),
        .mem_to_reg_i       (mem_to_reg_i),
        .reg_write_i        (reg_write_i),
        .write_register_i   (write_register_i),
        .alu_result_i       (alu_result_i),
        .read_data_2_i      (read_data_2_i),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_ack_i         (dmem_ack_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .stall_o            (stall_o),
        .wb_valid_o         (wb_valid_o),
        .wb_reg_write_o     (wb_reg_write_o),
        .wb_mem_to_reg_o    (wb_mem_to_reg_o),
        .wb_write_register_o(wb_write_register_o),
        .wb_alu_result_o    (wb_alu_result_o),
        .wb_read_data_o     (wb_read_data_o),
        .timeout_o          (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [4:0] rdst, input logic [31:0] alu, input logic [31:0] wd);
        mem_read_i       = rd;
        mem_write_i      = wr;
        mem_to_reg_i     = m2r;
        reg_write_i      = rw;
        write_register_i = rdst;
        alu_result_i     = alu;
        read_data_2_i    = wd;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        tick; tick;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
        checks++; if (wb_alu_result_o !== 32'h0) begin failures++; $display("FAIL reset_wb_alu got=%h exp=0", wb_alu_result_o); end
        reset = 1'b1;
    endtask

    task automatic test_alu_op;
        tick;
        drive(0, 0, 0, 1, 5'd5, 32'h0000_1234, 32'h0);
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
        tick;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (wb_alu_result_o !== 32'h0000_1234) begin failures++; $display("FAIL alu_result got=%h exp=00001234", wb_alu_result_o); end
        checks++; if (wb_write_register_o !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d exp=5", wb_write_register_o); end
        checks++; if (wb_reg_write_o !== 1'b1) begin failures++; $display("FAIL alu_reg_write got=%b exp=1", wb_reg_write_o); end
    endtask

    task automatic test_load;
        int stalls;
        tick;
        drive(1, 0, 1, 1, 5'd7, 32'h0000_0040, 32'h0);
        #1;
        stalls = 0;
        if (stall_o) stalls++;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL load_req_c0 got=%b exp=0", dmem_req_o); end
        tick; #1;
        if (stall_o) stalls++;
        checks++; if (dmem_req_o !== 1'b1) begin failures++; $display("FAIL load_req_c1 got=%b exp=1", dmem_req_o); end
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL load_bubble got=%b exp=0", wb_valid_o); end
        checks++; if (dmem_we_o !== 1'b0) begin failures++; $display("FAIL load_we got=%b exp=0", dmem_we_o); end
        tick; #1;
        if (stall_o) stalls++;
        checks++; if (dmem_addr_o !== 32'h40) begin failures++; $display("FAIL load_addr got=%h exp=00000040", dmem_addr_o); end
        tick;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        if (stall_o) stalls++;
        checks++; if (stalls !== 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stalls); end
        checks++; if (dmem_addr_o !== 32'h40) begin failures++; $display("FAIL load_addr_ack got=%h exp=00000040", dmem_addr_o); end
        tick;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL load_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (wb_read_data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", wb_read_data_o); end
        checks++; if (wb_mem_to_reg_o !== 1'b1) begin failures++; $display("FAIL load_mem_to_reg got=%b exp=1", wb_mem_to_reg_o); end
        checks++; if (wb_write_register_o !== 5'd7) begin failures++; $display("FAIL load_rd got=%0d exp=7", wb_write_register_o); end
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL load_req_drop got=%b exp=0", dmem_req_o); end
    endtask

    task automatic test_store;
        tick;
        drive(0, 1, 0, 0, 5'd0, 32'h0000_0080, 32'hCAFE_F00D);
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL store_stall_c0 got=%b exp=1", stall_o); end
        tick;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h1357_9BDF;
        #1;
        checks++; if (dmem_we_o !== 1'b1) begin failures++; $display("FAIL store_we got=%b exp=1", dmem_we_o); end
        checks++; if (dmem_wdata_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL store_wdata got=%h exp=cafef00d", dmem_wdata_o); end
        checks++; if (dmem_addr_o !== 32'h80) begin failures++; $display("FAIL store_addr got=%h exp=00000080", dmem_addr_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL store_stall_c1 got=%b exp=0", stall_o); end
        tick;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL store_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (wb_read_data_o !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", wb_read_data_o); end
    endtask

    task automatic test_back_to_back;
        tick;
        drive(1, 0, 1, 1, 5'd9, 32'h0000_0044, 32'h0);
        tick;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h1111_0000;
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall_ack got=%b exp=0", stall_o); end
        tick;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(0, 1, 0, 0, 5'd0, 32'h0000_0088, 32'h0000_2222);
        #1;
        checks++; if (wb_read_data_o !== 32'h1111_0000) begin failures++; $display("FAIL b2b_first_rdata got=%h exp=11110000", wb_read_data_o); end
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", stall_o); end
        tick;
        dmem_ack_i = 1'b1;
        #1;
        checks++; if (dmem_addr_o !== 32'h88 || dmem_we_o !== 1'b1 || dmem_req_o !== 1'b1) begin
            failures++; $display("FAIL b2b_second_req addr=%h we=%b req=%b exp=00000088/1/1", dmem_addr_o, dmem_we_o, dmem_req_o);
        end
        tick;
        dmem_ack_i = 1'b0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1 || wb_alu_result_o !== 32'h88) begin
            failures++; $display("FAIL b2b_second_wb valid=%b alu=%h exp=1/00000088", wb_valid_o, wb_alu_result_o);
        end
    endtask

    task automatic test_timeout;
        int reqs;
        tick;
        drive(1, 0, 1, 1, 5'd4, 32'h0000_0100, 32'h0);
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (dmem_req_o) reqs++;
        end
        checks++; if (reqs !== 4) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=4", reqs); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL timeout_stall got=%b exp=0", stall_o); end
        tick;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL timeout_req_drop got=%b exp=0", dmem_req_o); end
        checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timeout_o); end
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL timeout_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (wb_reg_write_o !== 1'b0) begin failures++; $display("FAIL timeout_reg_write got=%b exp=0", wb_reg_write_o); end
        checks++; if (wb_read_data_o !== 32'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0", wb_read_data_o); end
        tick;
        drive(0, 0, 0, 1, 5'd3, 32'h0000_0055, 32'h0);
        tick;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_alu_result_o !== 32'h55 || wb_reg_write_o !== 1'b1 || wb_valid_o !== 1'b1) begin
            failures++; $display("FAIL timeout_next_alu alu=%h rw=%b valid=%b exp=00000055/1/1", wb_alu_result_o, wb_reg_write_o, wb_valid_o);
        end
        checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout_o); end
    endtask

    task automatic test_reset_mid_access;
        tick;
        drive(1, 0, 1, 1, 5'd6, 32'h0000_0200, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", dmem_req_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall_o); end
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_wb_valid got=%b exp=0", wb_valid_o); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL rstmid_timeout got=%b exp=0", timeout_o); end
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        reset = 1'b1;
        tick;
        drive(1, 0, 1, 1, 5'd2, 32'h0000_0240, 32'h0);
        tick;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h0BAD_F00D;
        tick;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1 || wb_read_data_o !== 32'h0BAD_F00D || wb_write_register_o !== 5'd2) begin
            failures++; $display("FAIL rstmid_reload valid=%b rdata=%h rd=%0d exp=1/0badf00d/2", wb_valid_o, wb_read_data_o, wb_write_register_o);
        end
    endtask

    task automatic test_read_write_both;
        tick;
        drive(1, 1, 1, 1, 5'd8, 32'h0000_0300, 32'hA5A5_A5A5);
        tick;
        #1;
        checks++; if (dmem_we_o !== 1'b1) begin failures++; $display("FAIL both_we got=%b exp=1", dmem_we_o); end
        checks++; if (dmem_wdata_o !== 32'hA5A5_A5A5) begin failures++; $display("FAIL both_wdata got=%h exp=a5a5a5a5", dmem_wdata_o); end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hFFFF_FFFF;
        tick;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL both_wb_valid got=%b exp=1", wb_valid_o); end
        checks++; if (wb_read_data_o !== 32'h0) begin failures++; $display("FAIL both_rdata got=%h exp=0", wb_read_data_o); end
    endtask

    initial begin
        test_reset;
        test_alu_op;
        test_load;
        test_store;
        test_back_to_back;
        test_timeout;
        test_reset_mid_access;
        test_read_write_both;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
